mfcc_mean_acc: RTL and testbench

Parametrised per-utterance cepstral-mean engine for the MFCC front end. Per coefficient index, it sums the streamed MFCC coefficients over every frame of an utterance. When the utterance ends, it emits the exact per-coefficient means as a ready/valid stream to the downstream CMN/feature buffer. Compared with the previous generation, it is generalised in coefficient count and width, applies backpressure, computes an exact quotient with a sequential divider (no reciprocal ROM), and handles zero-frame and saturation cases.

---
 rtl/mfcc_pkg.sv | 29 ++
 rtl/mfcc_div_seq.sv | 92 +++++++++
 rtl/mfcc_mean_acc.sv | 215 +++++++++++++++++++++
 tb/tb_mfcc_mean_acc.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfcc_pkg.sv
// Shared definitions for the MFCC cepstral-mean block: FSM states, front-end
// default sizes and a constant-evaluable ceil(log2) helper.
package mfcc_pkg;

    localparam int unsigned NCOEF_DEF      = 13;
    localparam int unsigned DW_DEF         = 16;
    localparam int unsigned MAX_FRAMES_DEF = 1023;

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StDiv,
        StOut,
        StClr
    } mfcc_state_e;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mfcc_div_seq.sv
// Unsigned restoring divider, one quotient bit per cycle. The first step is
// taken in the start cycle itself, so done pulses exactly NW cycles after
// start with the full quotient on quotient_o. The divisor must be non-zero.
module mfcc_div_seq import mfcc_pkg::*; #(
    parameter int unsigned NW   = 26,
    parameter int unsigned DW_D = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [NW-1:0]   dividend_i,
    input  logic [DW_D-1:0] divisor_i,
    output logic [NW-1:0]   quotient_o,
    output logic            done_o
);

    localparam int unsigned CW = clog2(NW + 1);

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW_D-1:0] rem_q, rem_d;
    logic [DW_D-1:0] div_q, div_d;
    logic [NW-1:0]   quo_q, quo_d;

    logic [DW_D-1:0] step_rem;
    logic [DW_D-1:0] step_div;
    logic [NW-1:0]   step_quo;
    logic [DW_D:0]   rem_sh;
    logic            step_ge;
    logic [DW_D-1:0] rem_nxt;
    logic [NW-1:0]   quo_nxt;

    // One restoring step; at start it works straight from the input operands.
    always_comb begin
        step_rem = busy_q ? rem_q : '0;
        step_quo = busy_q ? quo_q : dividend_i;
        step_div = busy_q ? div_q : divisor_i;
        rem_sh   = {step_rem, step_quo[NW-1]};
        step_ge  = (rem_sh >= {1'b0, step_div});
        rem_nxt  = step_ge ? DW_D'(rem_sh - {1'b0, step_div}) : rem_sh[DW_D-1:0];
        quo_nxt  = {step_quo[NW-2:0], step_ge};
    end

    // Iteration control: the dividend shifts out while quotient bits shift in.
    always_comb begin
        busy_d = busy_q;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        div_d  = div_q;
        quo_d  = quo_q;
        if (busy_q) begin
            rem_d = rem_nxt;
            quo_d = quo_nxt;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = CW'(NW - 1);
            rem_d  = rem_nxt;
            quo_d  = quo_nxt;
            div_d  = divisor_i;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            quo_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            div_q  <= div_d;
            quo_q  <= quo_d;
        end
    end

    assign quotient_o = quo_q;
    assign done_o     = done_q;

endmodule

// File: rtl/mfcc_mean_acc.sv
// Per-utterance cepstral-mean engine: sums each MFCC coefficient index over
// all frames of an utterance, then streams the truncated-toward-zero means
// out one index at a time over a ready/valid interface.
module mfcc_mean_acc import mfcc_pkg::*; #(
    parameter  int unsigned NCOEF      = NCOEF_DEF,
    parameter  int unsigned DW         = DW_DEF,
    parameter  int unsigned MAX_FRAMES = MAX_FRAMES_DEF,
    localparam int unsigned FCW        = clog2(MAX_FRAMES + 1),
    localparam int unsigned ACC_W      = DW + FCW,
    localparam int unsigned IW         = clog2(NCOEF)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           utt_active_i,
    input  logic           coef_valid_i,
    input  logic           coef_first_i,
    input  logic [DW-1:0]  coef_i,
    output logic           mean_valid_o,
    input  logic           mean_ready_i,
    output logic [DW-1:0]  mean_data_o,
    output logic [IW-1:0]  mean_idx_o,
    output logic           mean_last_o,
    output logic [FCW-1:0] frame_count_o,
    output logic           busy_o,
    output logic           sat_o,
    output logic           drop_o
);

    mfcc_state_e state_q, state_d;

    logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
    logic             sat_q, sat_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             in_frame_q, in_frame_d;
    logic [IW-1:0]    k_q, k_d;
    logic [DW-1:0]    mean_q, mean_d;
    logic             div_started_q, div_started_d;
    logic             drop_q, drop_d;
    logic [ACC_W-1:0] acc_q [NCOEF];

    logic             acc_we;
    logic             acc_clr;
    logic [IW-1:0]    acc_widx;
    logic [ACC_W-1:0] coef_ext;

    logic [ACC_W-1:0] acc_sel;
    logic             acc_neg;
    logic [ACC_W-1:0] acc_abs;
    logic             div_start;
    logic             div_done;
    logic [ACC_W-1:0] div_quot;
    logic [DW-1:0]    quot_abs;
    logic             unused_quot_hi;

    assign coef_ext = {{FCW{coef_i[DW-1]}}, coef_i};

    // Divide |sum| and restore the sign afterwards so the result truncates
    // toward zero. |sum| <= frames * 2^(DW-1), so the quotient fits in DW bits.
    assign acc_sel        = acc_q[k_q];
    assign acc_neg        = acc_sel[ACC_W-1];
    assign acc_abs        = acc_neg ? (-acc_sel) : acc_sel;
    assign quot_abs       = div_quot[DW-1:0];
    assign unused_quot_hi = ^div_quot[ACC_W-1:DW];

    mfcc_div_seq #(
        .NW   (ACC_W),
        .DW_D (FCW)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start),
        .dividend_i (acc_abs),
        .divisor_i  (frame_cnt_q),
        .quotient_o (div_quot),
        .done_o     (div_done)
    );

    // FSM next-state, accumulation control and drop detection.
    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        sat_d         = sat_q;
        idx_d         = idx_q;
        in_frame_d    = in_frame_q;
        k_d           = k_q;
        mean_d        = mean_q;
        div_started_d = div_started_q;
        drop_d        = 1'b0;
        acc_we        = 1'b0;
        acc_clr       = 1'b0;
        acc_widx      = '0;
        div_start     = 1'b0;

        unique case (state_q)
            StIdle: begin
                drop_d = coef_valid_i;
                if (utt_active_i) begin
                    state_d     = StAccum;
                    frame_cnt_d = '0;
                    sat_d       = 1'b0;
                    idx_d       = '0;
                    in_frame_d  = 1'b0;
                end
            end
            StAccum: begin
                if (!utt_active_i) begin
                    state_d       = StDiv;
                    k_d           = '0;
                    div_started_d = 1'b0;
                    drop_d        = coef_valid_i;
                end else if (coef_valid_i) begin
                    if (coef_first_i) begin
                        // A frame beyond MAX_FRAMES is not counted; the rest of it
                        // is rejected through sat_q below.
                        if (frame_cnt_q == FCW'(MAX_FRAMES)) begin
                            sat_d  = 1'b1;
                            drop_d = 1'b1;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 1'b1;
                            idx_d       = '0;
                            in_frame_d  = 1'b1;
                            acc_we      = 1'b1;
                            acc_widx    = '0;
                        end
                    end else if (!in_frame_q || sat_q || idx_q == IW'(NCOEF - 1)) begin
                        drop_d = 1'b1;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        acc_we   = 1'b1;
                        acc_widx = idx_q + 1'b1;
                    end
                end
            end
            StDiv: begin
                drop_d = coef_valid_i;
                if (frame_cnt_q == '0) begin
                    mean_d  = '0;
                    state_d = StOut;
                end else if (!div_started_q) begin
                    div_start     = 1'b1;
                    div_started_d = 1'b1;
                end else if (div_done) begin
                    mean_d        = acc_neg ? (-quot_abs) : quot_abs;
                    div_started_d = 1'b0;
                    state_d       = StOut;
                end
            end
            StOut: begin
                drop_d = coef_valid_i;
                if (mean_ready_i) begin
                    if (k_q == IW'(NCOEF - 1)) begin
                        state_d = StClr;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = StDiv;
                    end
                end
            end
            StClr: begin
                drop_d  = coef_valid_i;
                acc_clr = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            frame_cnt_q   <= '0;
            sat_q         <= 1'b0;
            idx_q         <= '0;
            in_frame_q    <= 1'b0;
            k_q           <= '0;
            mean_q        <= '0;
            div_started_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            sat_q         <= sat_d;
            idx_q         <= idx_d;
            in_frame_q    <= in_frame_d;
            k_q           <= k_d;
            mean_q        <= mean_d;
            div_started_q <= div_started_d;
            drop_q        <= drop_d;
        end
    end

    // Accumulator bank: one signed add per accepted coefficient, bulk clear.
    always_ff @(posedge clk) begin
        if (!rst_n || acc_clr) begin
            for (int i = 0; i < NCOEF; i++) begin
                acc_q[i] <= '0;
            end
        end else if (acc_we) begin
            acc_q[acc_widx] <= acc_q[acc_widx] + coef_ext;
        end
    end

    assign mean_valid_o  = (state_q == StOut);
    assign mean_data_o   = mean_q;
    assign mean_idx_o    = k_q;
    assign mean_last_o   = (state_q == StOut) && (k_q == IW'(NCOEF - 1));
    assign frame_count_o = frame_cnt_q;
    assign busy_o        = (state_q != StIdle);
    assign sat_o         = sat_q;
    assign drop_o        = drop_q;

endmodule

// File: tb/tb_mfcc_mean_acc.sv
// Bench for mfcc_mean_acc: directed and random utterances, a reference model
// predicting the mean stream and drop count, and a scoreboard monitor.
module tb_mfcc_mean_acc;

    localparam int NCOEF      = 13;
    localparam int DW         = 16;
    localparam int MAX_FRAMES = 4;
    localparam int FCW        = $clog2(MAX_FRAMES + 1);
    localparam int ACC_W      = DW + FCW;
    localparam int IW         = $clog2(NCOEF);
    localparam int LIMIT      = 3000;

    typedef struct {
        bit first;
        int val;
    } stim_t;

    typedef struct {
        int idx;
        int data;
        bit last;
        int frames;
        bit sat;
        bit chk_gap;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           utt_active;
    logic           coef_valid;
    logic           coef_first;
    logic [DW-1:0]  coef;
    logic           mean_valid;
    logic           mean_ready;
    logic [DW-1:0]  mean_data;
    logic [IW-1:0]  mean_idx;
    logic           mean_last;
    logic [FCW-1:0] frame_count;
    logic           busy;
    logic           sat;
    logic           drop;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    drop_cnt = 0;
    int    ready_mode;
    int    stall_cnt;
    stim_t st[$];
    exp_t  exp_q[$];

    mfcc_mean_acc #(
        .NCOEF      (NCOEF),
        .DW         (DW),
        .MAX_FRAMES (MAX_FRAMES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .utt_active_i  (utt_active),
        .coef_valid_i  (coef_valid),
        .coef_first_i  (coef_first),
        .coef_i        (coef),
        .mean_valid_o  (mean_valid),
        .mean_ready_i  (mean_ready),
        .mean_data_o   (mean_data),
        .mean_idx_o    (mean_idx),
        .mean_last_o   (mean_last),
        .frame_count_o (frame_count),
        .busy_o        (busy),
        .sat_o         (sat),
        .drop_o        (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test, expected completion before time limit");
        $fatal(1, "time limit reached");
    end

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void push(input bit f, input int v);
        stim_t s;
        s.first = f;
        s.val   = v;
        st.push_back(s);
    endfunction

    function automatic int rnd_coef();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Reference: group the stream into frames, sum per index over the first
    // MAX_FRAMES frames, divide with C-style truncation. Returns drop count.
    function automatic int predict(input bit chk_gap);
        int sums[NCOEF];
        int frames = 0;
        bit sat_e  = 0;
        int drops  = 0;
        int pos    = -1;
        exp_t e;
        for (int k = 0; k < NCOEF; k++) sums[k] = 0;
        foreach (st[i]) begin
            if (st[i].first) begin
                if (frames == MAX_FRAMES) begin
                    sat_e = 1;
                    pos   = -1;
                    drops++;
                end else begin
                    frames++;
                    pos = 0;
                    sums[0] += st[i].val;
                end
            end else if (pos < 0 || pos + 1 >= NCOEF) begin
                drops++;
            end else begin
                pos++;
                sums[pos] += st[i].val;
            end
        end
        for (int k = 0; k < NCOEF; k++) begin
            e.idx     = k;
            e.data    = (frames == 0) ? 0 : sums[k] / frames;
            e.last    = (k == NCOEF - 1);
            e.frames  = frames;
            e.sat     = sat_e;
            e.chk_gap = chk_gap;
            exp_q.push_back(e);
        end
        return drops;
    endfunction

    // Monitor: scoreboard pops on every handshake; stalled outputs must hold.
    initial begin
        exp_t e;
        bit   prev_stall = 0;
        int   prev_data = 0;
        int   prev_idx = 0;
        int   last_hs = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
                continue;
            end
            if (drop) drop_cnt++;
            if (prev_stall) begin
                check("hold_valid", int'(mean_valid), 1);
                check("hold_data", int'($signed(mean_data)), prev_data);
                check("hold_idx", int'(mean_idx), prev_idx);
            end
            if (mean_valid && mean_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got idx %0d, expected no output",
                             mean_idx);
                end else begin
                    e = exp_q.pop_front();
                    check("mean_idx", int'(mean_idx), e.idx);
                    check("mean_data", int'($signed(mean_data)), e.data);
                    check("mean_last", int'(mean_last), int'(e.last));
                    check("frame_count", int'(frame_count), e.frames);
                    check("sat", int'(sat), int'(e.sat));
                    if (e.chk_gap && e.idx > 0) begin
                        check("spacing", cyc - last_hs, (e.frames == 0) ? 2 : ACC_W + 2);
                    end
                end
                last_hs = cyc;
            end
            prev_stall = mean_valid && !mean_ready;
            prev_data  = int'($signed(mean_data));
            prev_idx   = int'(mean_idx);
        end
    end

    // Downstream ready generator.
    initial begin
        mean_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: mean_ready = 1'b1;
                1: mean_ready = ($urandom_range(0, 99) < 70);
                2: begin
                    if (mean_valid && mean_idx == 4 && stall_cnt < 20) begin
                        mean_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        mean_ready = 1'b1;
                    end
                end
                default: mean_ready = !(mean_valid && mean_idx == 6);
            endcase
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, int'(mean_valid), 0);
        check({tag, "_data"}, int'(mean_data), 0);
        check({tag, "_idx"}, int'(mean_idx), 0);
        check({tag, "_last"}, int'(mean_last), 0);
        check({tag, "_frames"}, int'(frame_count), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_sat"}, int'(sat), 0);
        check({tag, "_drop"}, int'(drop), 0);
    endtask

    task automatic drive_utt(input int gap_pct, input int extra, input bit fall_drop);
        @(posedge clk);
        #1;
        utt_active = 1'b1;
        coef_valid = 1'b0;
        @(posedge clk);
        #1;
        foreach (st[i]) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                coef_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            coef_valid = 1'b1;
            coef_first = st[i].first;
            coef       = DW'(st[i].val);
            @(posedge clk);
            #1;
        end
        coef_valid = 1'b0;
        coef_first = 1'b0;
        repeat (extra) begin
            @(posedge clk);
            #1;
        end
        utt_active = 1'b0;
        if (fall_drop) begin
            coef_valid = 1'b1;
            coef_first = 1'b1;
            coef       = 16'h1234;
        end
        @(posedge clk);
        #1;
        coef_valid = 1'b0;
        coef_first = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (n >= LIMIT) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d outputs pending, expected 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_utt(input int gap_pct, input int extra, input bit fall_drop,
                           input string tag);
        int exp_drops;
        int d0;
        exp_drops = predict(ready_mode == 0) + int'(fall_drop);
        d0 = drop_cnt;
        drive_utt(gap_pct, extra, fall_drop);
        wait_idle(tag);
        check({tag, "_drops"}, drop_cnt - d0, exp_drops);
    endtask

    initial begin
        int nf;
        int nj;
        int len;
        int n;
        int vcnt;
        rst_n      = 1'b0;
        utt_active = 1'b0;
        coef_valid = 1'b0;
        coef_first = 1'b0;
        coef       = '0;
        ready_mode = 0;
        stall_cnt  = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;

        // Three frames of 100k, 200k, 300k: mean 200k.
        st.delete();
        for (int f = 1; f <= 3; f++) begin
            for (int k = 0; k < NCOEF; k++) push(k == 0, 100 * f * k);
        end
        run_utt(0, 0, 0, "basic");

        // Truncation toward zero: -16/3 = -5, 15/2 = 7.
        st.delete();
        push(1, -5);
        push(1, -5);
        push(1, -6);
        run_utt(0, 0, 0, "neg_trunc");
        st.delete();
        push(1, 7);
        push(1, 8);
        run_utt(0, 0, 0, "pos_trunc");

        // No coefficients at all: all-zero means at the short spacing.
        st.delete();
        run_utt(0, 3, 0, "zero_frames");

        // Hold idx 4 for 20 cycles.
        ready_mode = 2;
        stall_cnt  = 0;
        st.delete();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < NCOEF; k++) push(k == 0, rnd_coef());
        end
        run_utt(20, 0, 0, "backpressure");
        check("stall_cycles", stall_cnt, 20);
        ready_mode = 0;

        // Six frames against a limit of four.
        st.delete();
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < NCOEF; k++) push(k == 0, 10);
        end
        run_utt(0, 0, 0, "saturation");

        // A 14th coefficient plus a coefficient on the falling cycle.
        st.delete();
        for (int k = 0; k < NCOEF + 1; k++) push(k == 0, rnd_coef());
        for (int k = 0; k < NCOEF; k++) push(k == 0, rnd_coef());
        run_utt(0, 0, 1, "extra_coef");

        // Random utterances: leading junk, partial/long frames, gaps, backpressure.
        for (int u = 0; u < 20; u++) begin
            ready_mode = int'($urandom_range(0, 1));
            st.delete();
            nj = int'($urandom_range(0, 2));
            repeat (nj) push(0, rnd_coef());
            nf = int'($urandom_range(0, 6));
            repeat (nf) begin
                len = int'($urandom_range(1, 15));
                push(1, rnd_coef());
                for (int j = 1; j < len; j++) push(0, rnd_coef());
            end
            run_utt(int'($urandom_range(0, 1)) * 30, 0, bit'($urandom_range(0, 1)), "random");
        end

        // Reset while idx 6 is being presented.
        ready_mode = 3;
        st.delete();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < NCOEF; k++) push(k == 0, rnd_coef());
        end
        void'(predict(1'b0));
        drive_utt(0, 0, 0);
        n = 0;
        while (!(mean_valid && mean_idx == 6) && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_idx6", int'(n < LIMIT), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset("midout_reset");
        exp_q.delete();
        ready_mode = 0;
        rst_n = 1'b1;
        vcnt = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (mean_valid) vcnt++;
        end
        check("no_valid_after_reset", vcnt, 0);

        // One frame of coef = k must give means k if the bank was cleared.
        st.delete();
        for (int k = 0; k < NCOEF; k++) push(k == 0, k);
        run_utt(0, 0, 0, "post_reset");

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
